ddr_burst_arbiter: RTL and testbench

Shares the single burst port of ddr_controller between three requesters: instruction-cache read, data-cache read (including jump-address read) and data-cache store. It arbitrates round-robin, latches the winner's address and length, and drives the rd/wr burst request to ddr_controller until the matching finish arrives. It steers rd_burst_data_valid back to the owning cache and reports a per-requester done pulse. It sits between DDR_cache_interface's request logic and ddr_controller, in the ui_clk domain.

---
 rtl/ddr_arb_pkg.sv | 35 +++
 rtl/ddr_burst_arbiter_rr_arbiter3.sv | 33 +++
 rtl/ddr_burst_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR burst-port arbiter: FSM states,
// requester identifiers and default widths.
package ddr_arb_pkg;

  localparam int DEF_DDR_ADDR_WIDTH  = 28;
  localparam int DEF_BURST_LEN_WIDTH = 10;
  localparam int DEF_INS_LEN_WIDTH   = 8;
  localparam int DEF_TIMEOUT_CYCLES  = 4096;
  localparam int NUM_REQ             = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_BURST = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_INS    = 2'd0,
    REQ_DAT_RD = 2'd1,
    REQ_DAT_WR = 2'd2
  } req_id_t;

  // Round-robin successor: ins -> dat_rd -> dat_wr -> ins.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  function automatic req_id_t onehot_to_id(input logic [2:0] oh);
    if (oh[1]) return REQ_DAT_RD;
    if (oh[2]) return REQ_DAT_WR;
    return REQ_INS;
  endfunction

endpackage

// File: rtl/ddr_burst_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant searched from the pointer,
// and the pointer register that moves past each finished owner.
module rr_arbiter3
  import ddr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       adv,
  input  logic [1:0] adv_id,
  output logic [2:0] grant,
  output logic [1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_INS;
    end else if (adv) begin
      ptr <= rr_next(adv_id);
    end
  end

  always_comb begin
    logic [1:0] idx;
    grant = '0;
    idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[idx] && (grant == '0)) grant[idx] = 1'b1;
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Shares the ddr_controller burst port between instruction read, data read
// and data store requesters, with per-owner data-valid steering and a watchdog.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH  = DEF_DDR_ADDR_WIDTH,
  parameter int BURST_LEN_WIDTH = DEF_BURST_LEN_WIDTH,
  parameter int INS_LEN_WIDTH   = DEF_INS_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_calib_complete,
  input  logic                       ins_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  ins_addr,
  input  logic [INS_LEN_WIDTH-1:0]   ins_len,
  output logic                       ins_done,
  output logic                       ins_reading,
  output logic                       ins_data_valid,
  input  logic                       dat_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  dat_rd_addr,
  input  logic [BURST_LEN_WIDTH-1:0] dat_rd_len,
  input  logic                       dat_wr_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  dat_wr_addr,
  input  logic [BURST_LEN_WIDTH-1:0] dat_wr_len,
  output logic                       dat_done,
  output logic                       data_reading,
  output logic                       dat_data_valid,
  output logic                       rd_burst_req,
  output logic                       wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr,
  output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  input  logic                       rd_burst_finish,
  input  logic                       wr_burst_finish,
  input  logic                       rd_burst_data_valid,
  output logic                       timeout_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                     state;
  req_id_t                    owner;
  req_id_t                    win_id;
  logic [2:0]                 req_vec;
  logic [2:0]                 grant;
  logic [1:0]                 ptr;
  logic [DDR_ADDR_WIDTH-1:0]  win_addr;
  logic [BURST_LEN_WIDTH-1:0] win_len;
  logic [WD_W-1:0]            wd_cnt;
  logic                       finish_hit;

  assign req_vec = {dat_wr_req, dat_rd_req, ins_req};

  rr_arbiter3 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .adv    (state == S_DONE),
    .adv_id (owner),
    .grant  (grant),
    .ptr    (ptr)
  );

  always_comb begin
    win_id   = onehot_to_id(grant);
    win_addr = ins_addr;
    win_len  = BURST_LEN_WIDTH'(ins_len);
    case (win_id)
      REQ_DAT_RD: begin
        win_addr = dat_rd_addr;
        win_len  = dat_rd_len;
      end
      REQ_DAT_WR: begin
        win_addr = dat_wr_addr;
        win_len  = dat_wr_len;
      end
      default: ;
    endcase
  end

  // Only the finish that matches the outstanding burst type ends it.
  assign finish_hit = ((state == S_RD_BURST) && rd_burst_finish) ||
                      ((state == S_WR_BURST) && wr_burst_finish);

  assign ins_data_valid = rd_burst_data_valid & ins_reading;
  assign dat_data_valid = rd_burst_data_valid & data_reading;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      owner         <= REQ_INS;
      wd_cnt        <= '0;
      ins_done      <= 1'b0;
      dat_done      <= 1'b0;
      ins_reading   <= 1'b0;
      data_reading  <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
      rd_burst_len  <= '0;
      wr_burst_len  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      ins_done <= 1'b0;
      dat_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init_calib_complete && (req_vec != 3'b000)) begin
            owner <= win_id;
            if (win_id == REQ_DAT_WR) begin
              wr_burst_addr <= win_addr;
              wr_burst_len  <= win_len;
            end else begin
              rd_burst_addr <= win_addr;
              rd_burst_len  <= win_len;
            end
            if (win_len == '0) begin
              state <= S_DONE;
            end else if (win_id == REQ_DAT_WR) begin
              wr_burst_req <= 1'b1;
              state        <= S_WR_BURST;
            end else begin
              rd_burst_req <= 1'b1;
              ins_reading  <= (win_id == REQ_INS);
              data_reading <= (win_id == REQ_DAT_RD);
              state        <= S_RD_BURST;
            end
          end
        end
        S_RD_BURST, S_WR_BURST: begin
          if (finish_hit) begin
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            state        <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err  <= 1'b1;
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            state        <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          ins_done     <= (owner == REQ_INS);
          dat_done     <= (owner != REQ_INS);
          ins_reading  <= 1'b0;
          data_reading <= 1'b0;
          wd_cnt       <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter: expected burst starts and done pulses
// are queued as stimulus is driven and matched as the DUT emits them.
module tb_ddr_burst_arbiter;

  localparam int AW  = 28;
  localparam int LW  = 10;
  localparam int IW  = 8;
  localparam int TMO = 16;

  typedef struct packed {
    logic [2:0]    kind;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } ev_t;

  localparam logic [2:0] K_RD_INS = 3'd1, K_RD_DAT = 3'd2, K_WR = 3'd3,
                         K_DONE_INS = 3'd4, K_DONE_DAT = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic          ins_req = 1'b0, dat_rd_req = 1'b0, dat_wr_req = 1'b0;
  logic [AW-1:0] ins_addr = '0, dat_rd_addr = '0, dat_wr_addr = '0;
  logic [IW-1:0] ins_len = '0;
  logic [LW-1:0] dat_rd_len = '0, dat_wr_len = '0;
  logic          rd_burst_finish = 1'b0, wr_burst_finish = 1'b0;
  logic          rd_burst_data_valid = 1'b0;
  logic          ins_done, ins_reading, ins_data_valid;
  logic          dat_done, data_reading, dat_data_valid;
  logic          rd_burst_req, wr_burst_req, timeout_err;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [LW-1:0] rd_burst_len, wr_burst_len;
  logic [84:0]   all_out;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  assign all_out = {ins_done, ins_reading, ins_data_valid, dat_done, data_reading,
                    dat_data_valid, rd_burst_req, wr_burst_req, rd_burst_addr,
                    wr_burst_addr, rd_burst_len, wr_burst_len, timeout_err};

  ddr_burst_arbiter #(
    .DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .INS_LEN_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_len(ins_len),
    .ins_done(ins_done), .ins_reading(ins_reading), .ins_data_valid(ins_data_valid),
    .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
    .dat_wr_req(dat_wr_req), .dat_wr_addr(dat_wr_addr), .dat_wr_len(dat_wr_len),
    .dat_done(dat_done), .data_reading(data_reading), .dat_data_valid(dat_data_valid),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .timeout_err(timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_burst(output bit ok);
    int n = 0;
    while (!(rd_burst_req || wr_burst_req) && n < 50) begin
      tick(1);
      n++;
    end
    ok = rd_burst_req || wr_burst_req;
  endtask

  task automatic finish_burst(input int lat);
    bit w;
    w = wr_burst_req;
    tick(lat);
    if (w) wr_burst_finish = 1'b1;
    else   rd_burst_finish = 1'b1;
    tick(1);
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
  endtask

  task automatic monitor();
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    ev_t  acts[4];
    ev_t  e;
    int   na;
    forever begin
      @(negedge clk);
      na = 0;
      if (rd_burst_req && !prev_rd) begin
        acts[na] = '{kind: ins_reading ? K_RD_INS : (data_reading ? K_RD_DAT : 3'd7),
                     addr: rd_burst_addr, len: rd_burst_len};
        na++;
      end
      if (wr_burst_req && !prev_wr) begin
        acts[na] = '{kind: K_WR, addr: wr_burst_addr, len: wr_burst_len};
        na++;
      end
      if (ins_done) begin
        acts[na] = '{kind: K_DONE_INS, addr: '0, len: '0};
        na++;
      end
      if (dat_done) begin
        acts[na] = '{kind: K_DONE_DAT, addr: '0, len: '0};
        na++;
      end
      for (int k = 0; k < na; k++) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL event_unexpected: got kind=%0d addr=%h len=%0d, required no event",
                   acts[k].kind, acts[k].addr, acts[k].len);
        end else begin
          e = exp_q.pop_front();
          if (acts[k] !== e) begin
            n_err++;
            $display("FAIL event_match: got kind=%0d addr=%h len=%0d, required kind=%0d addr=%h len=%0d",
                     acts[k].kind, acts[k].addr, acts[k].len, e.kind, e.addr, e.len);
          end
        end
      end
      prev_rd = rd_burst_req;
      prev_wr = wr_burst_req;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    rst = 1'b0;
    init_calib_complete = 1'b1;
    tick(1);
  endtask

  task automatic test_single_ins();
    int bad = 0;
    ins_addr = 28'h100; ins_len = 8'd8; ins_req = 1'b1;
    exp_q.push_back('{kind: K_RD_INS, addr: 28'h100, len: 10'd8});
    exp_q.push_back('{kind: K_DONE_INS, addr: '0, len: '0});
    tick(1);
    n_cmp++;
    if (rd_burst_req !== 1'b1 || rd_burst_addr !== 28'h100 || rd_burst_len !== 10'd8) begin
      n_err++;
      $display("FAIL single_req: got req=%b addr=%h len=%0d, required 1/100/8",
               rd_burst_req, rd_burst_addr, rd_burst_len);
    end
    ins_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!(rd_burst_req && ins_reading && !data_reading && !wr_burst_req)) bad++;
      wr_burst_finish     = (i == 3);
      rd_burst_data_valid = (i >= 5 && i < 8);
      #1;
      if (rd_burst_data_valid) begin
        n_cmp++;
        if (ins_data_valid !== 1'b1 || dat_data_valid !== 1'b0) begin
          n_err++;
          $display("FAIL single_valid_steer: got ins=%b dat=%b, required 1/0",
                   ins_data_valid, dat_data_valid);
        end
      end
      tick(1);
    end
    wr_burst_finish = 1'b0; rd_burst_data_valid = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL single_hold: got %0d bad cycles, required 0", bad);
    end
    rd_burst_finish = 1'b1;
    tick(1);
    rd_burst_finish = 1'b0;
    n_cmp++;
    if (rd_burst_req !== 1'b0 || ins_done !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: got req=%b done=%b, required 0/0", rd_burst_req, ins_done);
    end
    tick(1);
    n_cmp++;
    if (ins_done !== 1'b1 || dat_done !== 1'b0 || ins_reading !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got ins_done=%b dat_done=%b reading=%b, required 1/0/0",
               ins_done, dat_done, ins_reading);
    end
    tick(1);
    n_cmp++;
    if (ins_done !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_pulse: got %b, required 0", ins_done);
    end
  endtask

  task automatic test_contention();
    bit ok;
    rst = 1'b1;
    ins_addr = 28'h200;    ins_len = 8'd4;     ins_req = 1'b1;
    dat_rd_addr = 28'h300; dat_rd_len = 10'd5; dat_rd_req = 1'b1;
    dat_wr_addr = 28'h400; dat_wr_len = 10'd6; dat_wr_req = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.push_back('{kind: K_RD_INS, addr: 28'h200, len: 10'd4});
    exp_q.push_back('{kind: K_DONE_INS, addr: '0, len: '0});
    exp_q.push_back('{kind: K_RD_DAT, addr: 28'h300, len: 10'd5});
    exp_q.push_back('{kind: K_DONE_DAT, addr: '0, len: '0});
    exp_q.push_back('{kind: K_WR, addr: 28'h400, len: 10'd6});
    exp_q.push_back('{kind: K_DONE_DAT, addr: '0, len: '0});
    exp_q.push_back('{kind: K_RD_INS, addr: 28'h200, len: 10'd4});
    exp_q.push_back('{kind: K_DONE_INS, addr: '0, len: '0});
    for (int i = 0; i < 4; i++) begin
      wait_burst(ok);
      n_cmp++;
      if (!ok || wr_burst_req !== (i == 2)) begin
        n_err++;
        $display("FAIL contention_grant%0d: got found=%b wr=%b, required 1/%b",
                 i, ok, wr_burst_req, (i == 2));
      end
      if (i == 3) begin
        ins_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
      end
      finish_burst(3);
    end
    tick(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL contention_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_calib_gate();
    int hits = 0;
    init_calib_complete = 1'b0;
    dat_rd_addr = 28'h500; dat_rd_len = 10'd3; dat_rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (rd_burst_req || wr_burst_req) hits++;
    end
    n_cmp++;
    if (hits !== 0) begin
      n_err++;
      $display("FAIL calib_block: got %0d req cycles, required 0", hits);
    end
    exp_q.push_back('{kind: K_RD_DAT, addr: 28'h500, len: 10'd3});
    exp_q.push_back('{kind: K_DONE_DAT, addr: '0, len: '0});
    init_calib_complete = 1'b1;
    tick(1);
    n_cmp++;
    if (rd_burst_req !== 1'b1 || data_reading !== 1'b1) begin
      n_err++;
      $display("FAIL calib_first_grant: got req=%b reading=%b, required 1/1",
               rd_burst_req, data_reading);
    end
    dat_rd_req = 1'b0;
    finish_burst(2);
    tick(3);
  endtask

  task automatic test_zero_len();
    dat_wr_addr = 28'h600; dat_wr_len = 10'd0; dat_wr_req = 1'b1;
    exp_q.push_back('{kind: K_DONE_DAT, addr: '0, len: '0});
    tick(1);
    dat_wr_req = 1'b0;
    n_cmp++;
    if (wr_burst_req !== 1'b0 || dat_done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_g1: got wr=%b done=%b, required 0/0", wr_burst_req, dat_done);
    end
    tick(1);
    n_cmp++;
    if (dat_done !== 1'b1 || wr_burst_req !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: got done=%b wr=%b, required 1/0", dat_done, wr_burst_req);
    end
    tick(2);
  endtask

  task automatic test_timeout();
    int  n = 0;
    bit  ok;
    ins_addr = 28'h700; ins_len = 8'd2; ins_req = 1'b1;
    exp_q.push_back('{kind: K_RD_INS, addr: 28'h700, len: 10'd2});
    exp_q.push_back('{kind: K_DONE_INS, addr: '0, len: '0});
    tick(1);
    ins_req = 1'b0;
    while (rd_burst_req && n < 40) begin
      n++;
      tick(1);
    end
    n_cmp++;
    if (n !== TMO || timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_len: got %0d cycles err=%b, required %0d/1", n, timeout_err, TMO);
    end
    tick(1);
    n_cmp++;
    if (ins_done !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_done: got %b, required 1", ins_done);
    end
    dat_rd_addr = 28'h800; dat_rd_len = 10'd7; dat_rd_req = 1'b1;
    exp_q.push_back('{kind: K_RD_DAT, addr: 28'h800, len: 10'd7});
    exp_q.push_back('{kind: K_DONE_DAT, addr: '0, len: '0});
    wait_burst(ok);
    dat_rd_req = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL timeout_next_served: got no burst, required burst");
    end
    finish_burst(2);
    tick(3);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b, required 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int  d = 0;
    bit  ok;
    ins_addr = 28'h900; ins_len = 8'd4; ins_req = 1'b1;
    exp_q.push_back('{kind: K_RD_INS, addr: 28'h900, len: 10'd4});
    tick(1);
    ins_req = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h, required 0", all_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (ins_done || dat_done) d++;
    end
    n_cmp++;
    if (d !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got %0d pulses, required 0", d);
    end
    ins_addr = 28'hA00; ins_len = 8'd4; ins_req = 1'b1;
    dat_wr_addr = 28'hB00; dat_wr_len = 10'd2; dat_wr_req = 1'b1;
    exp_q.push_back('{kind: K_RD_INS, addr: 28'hA00, len: 10'd4});
    exp_q.push_back('{kind: K_DONE_INS, addr: '0, len: '0});
    wait_burst(ok);
    ins_req = 1'b0; dat_wr_req = 1'b0;
    n_cmp++;
    if (!ok || rd_burst_req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_ptr: got found=%b rd=%b, required 1/1", ok, rd_burst_req);
    end
    finish_burst(2);
    tick(3);
  endtask

  initial begin
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, required finish");
        $fatal(1);
      end
    join_none
    test_reset();
    test_single_ins();
    test_contention();
    test_calib_gate();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    tick(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
